tcd1290d_timing_gen: RTL and testbench
======================================

TCD1290D_TIMING_GEN -- requirements
Module: tcd1290d_timing_gen

Interface
REQ-001 SHALL have parameter HALF_DIV, default 10, meaning sys_clk cycles per pclk half-period (pixel period = 2*HALF_DIV).
REQ-002 SHALL have parameter SAMP_NUM, default 2088, meaning pixels per frame readout.
REQ-003 SHALL have parameter RS_WIDTH, default 2, meaning rs_plus high width in sys_clk cycles (1 <= RS_WIDTH < HALF_DIV).
REQ-004 SHALL have parameter SH_WIDTH, default 100, meaning sh high width in sys_clk cycles.
REQ-005 SHALL have parameter SH_GUARD, default 50, meaning phi1-held-high cycles before and after sh.
REQ-006 SHALL use one clock and asynchronous active-low reset: sys_clk input 1 (100 MHz system clock), then sys_rst_n input 1 (async reset, active low).
REQ-007 SHALL have frame_start input 1: single-cycle request for one integration/readout frame.
REQ-008 SHALL have pclk output 1: CCD pixel clock (phi1), also the AFE DATACLK source.
REQ-009 SHALL have phi2 output 1: always ~pclk.
REQ-010 SHALL have rs_plus output 1: CCD reset-gate pulse, active high.
REQ-011 SHALL have sh output 1: CCD shift gate, active high.
REQ-012 SHALL have os_tvalid output 1: high for exactly the SAMP_NUM readout pixel periods.
REQ-013 SHALL have busy output 1, frame_done output 1 (one-cycle pulse), overrun output 1 (one-cycle pulse).

Function
REQ-014 div_cnt SHALL count 0..2*HALF_DIV-1 and wrap; pclk = 1 while div_cnt < HALF_DIV, else 0, in states IDLE and READOUT.
REQ-015 rs_plus SHALL be 1 while div_cnt < RS_WIDTH in IDLE and READOUT, and 0 in all SH states.
REQ-016 States SHALL be IDLE, SH_PRE, SH_PULSE, SH_POST, READOUT; busy = 1 in every state except IDLE.
REQ-017 frame_start in IDLE SHALL set a pending flag; IDLE->SH_PRE SHALL occur on the cycle div_cnt = 2*HALF_DIV-1 while pending is set, which clears pending.
REQ-018 frame_start while busy=1 or pending=1 SHALL be ignored and SHALL pulse overrun for 1 cycle.
REQ-019 SH_PRE SHALL last SH_GUARD cycles, SH_PULSE SH_WIDTH cycles, SH_POST SH_GUARD cycles; pclk SHALL be held 1 throughout all three.
REQ-020 sh SHALL be 1 exactly during SH_PULSE, never overlapping a pclk low phase.
REQ-021 On SH_POST exit, div_cnt SHALL restart at 0 and the state SHALL enter READOUT with os_tvalid = 1 on that same cycle.
REQ-022 READOUT SHALL last SAMP_NUM*2*HALF_DIV cycles, counted by pix_cnt (12 bits, 0..SAMP_NUM-1, incremented at div_cnt wrap).
REQ-023 At the final wrap (pix_cnt = SAMP_NUM-1, div_cnt = 2*HALF_DIV-1), state SHALL return to IDLE, os_tvalid SHALL drop, and frame_done SHALL pulse 1 cycle.
REQ-024 frame_start on the frame_done cycle SHALL be accepted as a new pending request without overrun.
REQ-025 pclk, phi2, rs_plus, sh and os_tvalid SHALL be registered outputs, glitch-free, with no combinational path from frame_start.

Reset
REQ-026 On sys_rst_n = 0 (async), state SHALL be IDLE and div_cnt, pix_cnt and pending SHALL be 0.
REQ-027 During and after reset, outputs SHALL be pclk=0, phi2=1, rs_plus=0, sh=0, os_tvalid=0, busy=0, frame_done=0, overrun=0.
REQ-028 Reset asserted mid-frame SHALL abort immediately with no sh or os_tvalid glitch; free-running pclk SHALL resume at div_cnt=0 after release.

Structure
REQ-029 State encoding and the SAMP_NUM/HALF_DIV/RS_WIDTH/SH_WIDTH/SH_GUARD defaults SHALL live in shared package ccd_timing_pkg, used also by the AFE driver.
REQ-030 The div_cnt counter with pclk/rs_plus generation SHALL be sub-module ccd_pix_div (inputs: hold_high, restart; outputs: pclk, rs_plus, wrap).

Verification (bench: HALF_DIV=4, SAMP_NUM=16, RS_WIDTH=2, SH_WIDTH=10, SH_GUARD=5)
REQ-031 Idle free-run: no frame_start for 100 cycles -> pclk period 8 cycles, 4 high/4 low; rs_plus high cycles 0-1 of each period; sh=0, os_tvalid=0.
REQ-032 Single frame: frame_start pulse -> SH_PRE at next div_cnt=7; sh high exactly 10 cycles after 5 pclk-high cycles; os_tvalid high exactly 128 cycles; frame_done pulses once.
REQ-033 Overrun: second frame_start during READOUT -> overrun 1-cycle pulse, no second sh pulse, frame length unchanged.
REQ-034 Back-to-back: frame_start on frame_done cycle -> second frame starts at next pixel boundary, overrun stays 0.
REQ-035 Reset mid-SH_PULSE: sys_rst_n low 3 cycles -> sh, os_tvalid, busy go 0 immediately; after release, pclk restarts and no frame begins without a new frame_start.
REQ-036 Defaults run (HALF_DIV=10, SAMP_NUM=2088): os_tvalid high exactly 41760 cycles per frame.

Source files
------------

// File: rtl/ccd_timing_pkg.sv
// Shared TCD1290D timing definitions: state encoding and default timing
// parameters, also used by the AFE driver.
package ccd_timing_pkg;

  localparam int DEF_HALF_DIV = 10;
  localparam int DEF_SAMP_NUM = 2088;
  localparam int DEF_RS_WIDTH = 2;
  localparam int DEF_SH_WIDTH = 100;
  localparam int DEF_SH_GUARD = 50;

  localparam int PIX_CNT_W = 12;
  localparam int SH_TMR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SH_PRE   = 3'd1,
    ST_SH_PULSE = 3'd2,
    ST_SH_POST  = 3'd3,
    ST_READOUT  = 3'd4
  } ccd_state_e;

  function automatic logic is_sh_state(input ccd_state_e st);
    return (st == ST_SH_PRE) || (st == ST_SH_PULSE) || (st == ST_SH_POST);
  endfunction

endpackage

// File: rtl/ccd_pix_div.sv
// Pixel-clock divider: free-running div_cnt with registered pclk/rs_plus
// decode; hold_high parks pclk high and freezes the count.
module ccd_pix_div
  import ccd_timing_pkg::*;
#(
  parameter int HALF_DIV = DEF_HALF_DIV,
  parameter int RS_WIDTH = DEF_RS_WIDTH
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic hold_high,
  input  logic restart,
  output logic pclk,
  output logic rs_plus,
  output logic wrap
);

  localparam int DIV_W = $clog2(2 * HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_RS   = DIV_W'(RS_WIDTH);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_next_s;
  logic             pclk_r;
  logic             rs_plus_r;

  assign wrap    = (div_cnt_r == DIV_LAST);
  assign pclk    = pclk_r;
  assign rs_plus = rs_plus_r;

  // Next divider count
  always_comb begin
    div_next_s = div_cnt_r;
    if (restart) begin
      div_next_s = '0;
    end else if (hold_high) begin
      div_next_s = div_cnt_r;
    end else if (wrap) begin
      div_next_s = '0;
    end else begin
      div_next_s = div_cnt_r + DIV_ONE;
    end
  end

  // Counter and registered phase decode (outputs trail div_cnt by one cycle)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_r <= '0;
      pclk_r    <= 1'b0;
      rs_plus_r <= 1'b0;
    end else begin
      div_cnt_r <= div_next_s;
      pclk_r    <= hold_high | (div_cnt_r < DIV_HALF);
      rs_plus_r <= ~hold_high & (div_cnt_r < DIV_RS);
    end
  end

endmodule

// File: rtl/tcd1290d_timing_gen.sv
// TCD1290D linear CCD timing generator: shift-gate sequence followed by a
// SAMP_NUM-pixel readout window, one frame per accepted frame_start.
module tcd1290d_timing_gen
  import ccd_timing_pkg::*;
#(
  parameter int HALF_DIV = DEF_HALF_DIV,
  parameter int SAMP_NUM = DEF_SAMP_NUM,
  parameter int RS_WIDTH = DEF_RS_WIDTH,
  parameter int SH_WIDTH = DEF_SH_WIDTH,
  parameter int SH_GUARD = DEF_SH_GUARD
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic frame_start,
  output logic pclk,
  output logic phi2,
  output logic rs_plus,
  output logic sh,
  output logic os_tvalid,
  output logic busy,
  output logic frame_done,
  output logic overrun
);

  localparam logic [PIX_CNT_W-1:0] PIX_LAST   = PIX_CNT_W'(SAMP_NUM - 1);
  localparam logic [PIX_CNT_W-1:0] PIX_ONE    = PIX_CNT_W'(1);
  localparam logic [SH_TMR_W-1:0]  GUARD_LAST = SH_TMR_W'(SH_GUARD - 1);
  localparam logic [SH_TMR_W-1:0]  PULSE_LAST = SH_TMR_W'(SH_WIDTH - 1);
  localparam logic [SH_TMR_W-1:0]  TMR_ONE    = SH_TMR_W'(1);

  ccd_state_e           state_r;
  ccd_state_e           state_next_s;
  logic                 pending_r;
  logic                 pending_next_s;
  logic [PIX_CNT_W-1:0] pix_cnt_r;
  logic [PIX_CNT_W-1:0] pix_next_s;
  logic [SH_TMR_W-1:0]  sh_tmr_r;
  logic [SH_TMR_W-1:0]  sh_tmr_next_s;
  logic                 hold_s;
  logic                 restart_s;
  logic                 wrap_s;
  logic                 pclk_s;
  logic                 rs_plus_s;
  logic                 sh_r;
  logic                 os_tvalid_r;
  logic                 busy_r;
  logic                 frame_done_r;
  logic                 overrun_r;

  assign hold_s = is_sh_state(state_r);

  ccd_pix_div #(
    .HALF_DIV (HALF_DIV),
    .RS_WIDTH (RS_WIDTH)
  ) u_pix_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .hold_high (hold_s),
    .restart   (restart_s),
    .pclk      (pclk_s),
    .rs_plus   (rs_plus_s),
    .wrap      (wrap_s)
  );

  // Frame sequencing: next state, shift-gate timer, pixel counter, pending request
  always_comb begin
    state_next_s   = state_r;
    pending_next_s = pending_r;
    pix_next_s     = pix_cnt_r;
    sh_tmr_next_s  = sh_tmr_r;
    restart_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pix_next_s    = '0;
        sh_tmr_next_s = '0;
        if (pending_r && wrap_s) begin
          state_next_s   = ST_SH_PRE;
          pending_next_s = 1'b0;
        end else if (frame_start && !busy_r) begin
          pending_next_s = 1'b1;
        end else begin
          pending_next_s = pending_r;
        end
      end
      ST_SH_PRE: begin
        if (sh_tmr_r == GUARD_LAST) begin
          state_next_s  = ST_SH_PULSE;
          sh_tmr_next_s = '0;
        end else begin
          sh_tmr_next_s = sh_tmr_r + TMR_ONE;
        end
      end
      ST_SH_PULSE: begin
        if (sh_tmr_r == PULSE_LAST) begin
          state_next_s  = ST_SH_POST;
          sh_tmr_next_s = '0;
        end else begin
          sh_tmr_next_s = sh_tmr_r + TMR_ONE;
        end
      end
      ST_SH_POST: begin
        if (sh_tmr_r == GUARD_LAST) begin
          state_next_s  = ST_READOUT;
          sh_tmr_next_s = '0;
          restart_s     = 1'b1;
        end else begin
          sh_tmr_next_s = sh_tmr_r + TMR_ONE;
        end
      end
      ST_READOUT: begin
        if (wrap_s && (pix_cnt_r == PIX_LAST)) begin
          state_next_s = ST_IDLE;
          pix_next_s   = '0;
        end else if (wrap_s) begin
          pix_next_s = pix_cnt_r + PIX_ONE;
        end else begin
          pix_next_s = pix_cnt_r;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        pending_next_s = 1'b0;
        pix_next_s     = '0;
        sh_tmr_next_s  = '0;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
      pix_cnt_r <= '0;
      sh_tmr_r  <= '0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_next_s;
      pix_cnt_r <= pix_next_s;
      sh_tmr_r  <= sh_tmr_next_s;
    end
  end

  // Status outputs, registered in step with the divider's pclk decode
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_r         <= 1'b0;
      os_tvalid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      sh_r         <= (state_r == ST_SH_PULSE);
      os_tvalid_r  <= (state_r == ST_READOUT);
      busy_r       <= (state_r != ST_IDLE);
      frame_done_r <= os_tvalid_r & (state_r != ST_READOUT);
      overrun_r    <= frame_start & ((state_r != ST_IDLE) | pending_r | busy_r);
    end
  end

  assign pclk       = pclk_s;
  assign phi2       = ~pclk_s;
  assign rs_plus    = rs_plus_s;
  assign sh         = sh_r;
  assign os_tvalid  = os_tvalid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_tcd1290d_timing_gen.sv
// Directed bench for tcd1290d_timing_gen: idle phase table plus frame,
// overrun, back-to-back, mid-frame reset and default-parameter sequences.
`timescale 1ns/1ps
module tb_tcd1290d_timing_gen;

  localparam int HD  = 4;
  localparam int SN  = 16;
  localparam int RSW = 2;
  localparam int SHW = 10;
  localparam int SHG = 5;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  logic frame_start = 1'b0;
  logic frame_start_def = 1'b0;
  logic pclk, phi2, rs_plus, sh, os_tvalid, busy, frame_done, overrun;
  logic d_pclk, d_phi2, d_rs_plus, d_sh, d_os_tvalid, d_busy, d_frame_done, d_overrun;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic       frame_start;
    logic [7:0] exp_out;   // {pclk, phi2, rs_plus, sh, os_tvalid, busy, frame_done, overrun}
  } vec_t;
  vec_t tbl [8];

  int st_sh, st_sh_rise, st_tv, st_tv_rise, st_done, st_done_ok, st_ovr, st_busy;
  int st_pre_hi, st_pre_lo, st_sh_lowpclk, st_sh1_cyc, st_sh2_cyc, st_done_cyc;

  always #5 sys_clk = ~sys_clk;

  tcd1290d_timing_gen #(
    .HALF_DIV (HD), .SAMP_NUM (SN), .RS_WIDTH (RSW), .SH_WIDTH (SHW), .SH_GUARD (SHG)
  ) dut (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .frame_start (frame_start),
    .pclk (pclk), .phi2 (phi2), .rs_plus (rs_plus), .sh (sh), .os_tvalid (os_tvalid),
    .busy (busy), .frame_done (frame_done), .overrun (overrun)
  );

  tcd1290d_timing_gen dut_def (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .frame_start (frame_start_def),
    .pclk (d_pclk), .phi2 (d_phi2), .rs_plus (d_rs_plus), .sh (d_sh), .os_tvalid (d_os_tvalid),
    .busy (d_busy), .frame_done (d_frame_done), .overrun (d_overrun)
  );

  function automatic logic [7:0] out_vec();
    return {pclk, phi2, rs_plus, sh, os_tvalid, busy, frame_done, overrun};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Apply the phase table for nper pixel periods starting right after reset release.
  task automatic idle_table(input string tag, input int nper);
    for (int p = 0; p < nper; p++) begin
      for (int k = 0; k < 8; k++) begin
        frame_start = tbl[k].frame_start;
        @(negedge sys_clk);
        check($sformatf("%s_p%0d_ph%0d", tag, p, k), int'(out_vec()), int'(tbl[k].exp_out));
      end
    end
  endtask

  task automatic sync_phase0();
    logic prev;
    bit   found;
    prev  = pclk;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge sys_clk);
      if (pclk && !prev) found = 1'b1;
      prev = pclk;
    end
    check("sync_pclk_rise", int'(found), 1);
  endtask

  task automatic observe(input int ncyc, input int inj_tv, input bit inj_done);
    logic prev_sh, prev_tv, prev_pclk;
    int   hi_run, lo_run, last_lo;
    bit   injected;
    st_sh = 0; st_sh_rise = 0; st_tv = 0; st_tv_rise = 0; st_done = 0; st_done_ok = 0;
    st_ovr = 0; st_busy = 0; st_pre_hi = -1; st_pre_lo = -1; st_sh_lowpclk = 0;
    st_sh1_cyc = -1; st_sh2_cyc = -1; st_done_cyc = -1;
    prev_sh = sh; prev_tv = os_tvalid; prev_pclk = pclk;
    hi_run = 0; lo_run = 0; last_lo = 0; injected = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge sys_clk);
      frame_start = 1'b0;
      if (sh && !prev_sh) begin
        st_sh_rise++;
        if (st_sh_rise == 1) begin st_pre_hi = hi_run; st_pre_lo = last_lo; st_sh1_cyc = c; end
        if (st_sh_rise == 2) st_sh2_cyc = c;
      end
      if (pclk && !prev_pclk) begin last_lo = lo_run; hi_run = 0; end
      if (!pclk && prev_pclk) lo_run = 0;
      if (pclk) hi_run++; else lo_run++;
      if (sh) st_sh++;
      if (sh && !pclk) st_sh_lowpclk++;
      if (os_tvalid) st_tv++;
      if (os_tvalid && !prev_tv) st_tv_rise++;
      if (overrun) st_ovr++;
      if (busy) st_busy++;
      if (frame_done) begin
        st_done++;
        if (st_done == 1) st_done_cyc = c;
        if (prev_tv && !os_tvalid) st_done_ok++;
        if (inj_done && !injected) begin frame_start = 1'b1; injected = 1'b1; end
      end
      if (inj_tv >= 0 && st_tv == inj_tv && !injected) begin frame_start = 1'b1; injected = 1'b1; end
      prev_sh = sh; prev_tv = os_tvalid; prev_pclk = pclk;
    end
  endtask

  initial begin
    int tv_def, done_def;
    bit seen;
    tbl[0] = '{1'b0, 8'b1010_0000};
    tbl[1] = '{1'b0, 8'b1010_0000};
    tbl[2] = '{1'b0, 8'b1000_0000};
    tbl[3] = '{1'b0, 8'b1000_0000};
    tbl[4] = '{1'b0, 8'b0100_0000};
    tbl[5] = '{1'b0, 8'b0100_0000};
    tbl[6] = '{1'b0, 8'b0100_0000};
    tbl[7] = '{1'b0, 8'b0100_0000};

    // Reset state, then idle free-run
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", int'(out_vec()), int'(8'b0100_0000));
    sys_rst_n = 1'b1;
    check("release_outputs", int'(out_vec()), int'(8'b0100_0000));
    idle_table("idle", 12);

    // Single frame
    sync_phase0();
    frame_start = 1'b1;
    observe(200, -1, 1'b0);
    check("frame_sh_rises", st_sh_rise, 1);
    check("frame_sh_cycles", st_sh, SHW);
    check("frame_sh_start_cycle", st_sh1_cyc, 12);
    check("frame_pre_pclk_high", st_pre_hi, SHG);
    check("frame_prior_pclk_low", st_pre_lo, HD);
    check("frame_sh_in_pclk_low", st_sh_lowpclk, 0);
    check("frame_tvalid_cycles", st_tv, SN * 2 * HD);
    check("frame_tvalid_rises", st_tv_rise, 1);
    check("frame_done_pulses", st_done, 1);
    check("frame_done_at_tvalid_drop", st_done_ok, 1);
    check("frame_busy_cycles", st_busy, 2 * SHG + SHW + SN * 2 * HD);
    check("frame_overrun", st_ovr, 0);

    // Overrun during readout
    sync_phase0();
    frame_start = 1'b1;
    observe(200, 50, 1'b0);
    check("ovr_overrun_cycles", st_ovr, 1);
    check("ovr_sh_rises", st_sh_rise, 1);
    check("ovr_tvalid_cycles", st_tv, SN * 2 * HD);
    check("ovr_done_pulses", st_done, 1);

    // Back-to-back: new request on the frame_done cycle
    sync_phase0();
    frame_start = 1'b1;
    observe(400, -1, 1'b1);
    check("b2b_sh_rises", st_sh_rise, 2);
    check("b2b_tvalid_cycles", st_tv, 2 * SN * 2 * HD);
    check("b2b_tvalid_rises", st_tv_rise, 2);
    check("b2b_done_pulses", st_done, 2);
    check("b2b_overrun", st_ovr, 0);
    check("b2b_restart_gap", st_sh2_cyc - st_done_cyc, 13);

    // Reset asserted mid-SH_PULSE
    sync_phase0();
    frame_start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sys_clk);
      frame_start = 1'b0;
      if (sh) seen = 1'b1;
    end
    check("rst_sh_reached", int'(seen), 1);
    repeat (2) @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1 check("rst_immediate", int'(out_vec()), int'(8'b0100_0000));
    repeat (3) @(negedge sys_clk);
    check("rst_held", int'(out_vec()), int'(8'b0100_0000));
    sys_rst_n = 1'b1;
    idle_table("rst_idle", 4);
    observe(80, -1, 1'b0);
    check("rst_no_sh", st_sh, 0);
    check("rst_no_tvalid", st_tv, 0);
    check("rst_no_busy", st_busy, 0);

    // Default parameters: full-length readout
    @(negedge sys_clk);
    frame_start_def = 1'b1;
    tv_def = 0;
    done_def = 0;
    for (int c = 0; c < 42300; c++) begin
      @(negedge sys_clk);
      frame_start_def = 1'b0;
      if (d_os_tvalid) tv_def++;
      if (d_frame_done) done_def++;
    end
    check("def_tvalid_cycles", tv_def, 41760);
    check("def_done_pulses", done_def, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
